progressive_counter: RTL

PROGRESSIVE_COUNTER -- requirements
Module: progressive_counter

---
 rtl/progressive_counter.sv | 62 ++++++
 1 files changed

// File: rtl/progressive_counter.sv
// Loadable up-counter stepped by a synchronized async increment edge, with
// a runtime limit that either wraps to zero or saturates, and an overflow pulse.
module progressive_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] start_value,
  input  logic         load,
  input  logic         increment,
  input  logic [N-1:0] limit,
  input  logic         wrap_en,
  output logic [N-1:0] count,
  output logic         at_limit,
  output logic         overflow
);

  logic         s1, s2, s3;
  logic         inc_edge;
  logic [N-1:0] count_nxt;
  logic         overflow_nxt;

  // s1/s2 resolve metastability; s3 remembers the previous synchronized level
  assign inc_edge = s2 & ~s3;

  always_comb begin
    at_limit = (count >= limit);
  end

  // load wins over a coincident edge and the edge is dropped, not deferred
  always_comb begin
    count_nxt    = count;
    overflow_nxt = 1'b0;
    if (load) begin
      count_nxt = start_value;
    end else if (inc_edge) begin
      if (!at_limit) begin
        count_nxt = count + N'(1);
      end else begin
        overflow_nxt = 1'b1;
        if (wrap_en) count_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      s1       <= increment;
      s2       <= s1;
      s3       <= s2;
      count    <= count_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule
